ser_bus_master: RTL and testbench
=================================

# ser_bus_master

Serial-command bus initiator: turns a byte stream from a serial-line receiver into single-word read/write cycles on the system bus (stb/we/addr/dout in, din/ack back), and returns results as a byte stream to a serial-line transmitter. It sits beside the cpu as a second bus initiator for host-driven memory and I/O access, such as loading RAM or poking device registers. Arbitration against the cpu is outside this block; `busy` is provided for it.

## Interface
- TIMEOUT, 1024: cycles to wait for `bus_ack` before aborting a cycle; legal range 2..65535.
- clk  in  1  system clock (50 MHz domain)
- rst_n  in  1  reset; synchronous, active-low
- rx_data  in  8  command byte from serial receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- tx_data  out  8  response byte to serial transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  byte consumed when tx_valid && tx_ready
- bus_stb  out  1  bus strobe
- bus_we  out  1  bus write enable
- bus_addr  out  22  word address [23:2]
- bus_dout  out  32  write data
- bus_din  in  32  read data, sampled with bus_ack
- bus_ack  in  1  bus acknowledge
- busy  out  1  high from the first accepted command byte until the last response byte is consumed

## Operation
- Frame: command byte, then 3 address bytes (byte address, MSB first, bits 1:0 discarded). For write only, 4 data bytes follow, MSB first.
- Commands:
  - 0x01 = read word.
  - 0x02 = write word.
  - Any other byte: respond 0x15 (NAK), no bus cycle, return to IDLE.
- Responses:
  - Read success: 4 bytes of bus_din, MSB first.
  - Write success: 1 byte 0x06 (ACK).
  - Timeout: 1 byte 0x15; for a read, no data bytes.
- FSM states:
  - IDLE: rx_ready=1. On accepting 0x01/0x02 go to ADDR; otherwise go to RESP with NAK.
  - ADDR: accept 3 bytes via a 2-bit byte counter. Then read goes to BUS, write goes to DATA.
  - DATA: accept 4 bytes, then go to BUS.
  - BUS: stb=1, addr/we/dout held constant. On ack: latch bus_din and go to RESP. If the timeout counter reaches TIMEOUT-1 without ack, go to RESP with NAK.
  - RESP: present bytes in order; after the last handshake go to IDLE.
- rx_ready=1 only in IDLE, ADDR, DATA. Bytes arriving during BUS or RESP stay with the receiver (backpressure); none are dropped.
- No inter-byte timeout on the rx side: a partial frame waits indefinitely.
- Reset mid-frame or mid-cycle: all state discarded, stb dropped in the same cycle reset is sampled.

## Timing
- Reset values: rx_ready=0, tx_valid=0, tx_data=0x00, bus_stb=0, bus_we=0, bus_addr=0, bus_dout=0, busy=0. The FSM enters IDLE; rx_ready rises the cycle after rst_n goes high.
- All outputs are registered.
- bus_stb rises the cycle after the last frame byte handshake.
- bus_ack sampled high at edge N: stb is low from N+1 and tx_valid is high from N+1. The cycle is exactly one ack long, and the ack is never sampled twice.
- The timeout counter clears on entering BUS. With no ack, stb is high for exactly TIMEOUT cycles, then drops.
- An ack arriving on the same edge the timeout expires counts as success.
- tx_data/tx_valid are held stable until tx_ready. The next byte is presented the cycle after each handshake, so back-to-back bytes stream at 1 byte/cycle when tx_ready stays high.
- Minimum read latency, last rx byte to first tx byte, is 2 cycles with bus_ack combinational-high.

## Structure
- Shared package holds:
  - command codes CMD_READ=0x01, CMD_WRITE=0x02
  - response codes RSP_ACK=0x06, RSP_NAK=0x15
  - the FSM state enumeration
- Single module. A shift register for address/data assembly and one for response serialization are internal, with no sub-module.

## Test plan
- Read: rx 01 FF FF C4, slave acks after 3 cycles with din=0x12345678 -> bus_addr=0x3FFFF1, we=0, stb high 3 cycles; tx 12 34 56 78.
- Write: rx 02 00 01 00 DE AD BE EF, immediate ack -> bus_addr=0x000040, we=1, dout=0xDEADBEEF, stb high 1 cycle; tx 06.
- Bad command 0x7F -> no stb; tx 15; the next valid frame is processed normally.
- Timeout with TIMEOUT=16: read, no ack -> stb high exactly 16 cycles; tx 15 only.
- Backpressure: tx_ready toggled 1-of-3 cycles during a read response, and rx_valid held high during BUS -> bytes unchanged while stalled, no rx byte accepted until IDLE.
- Reset pulse of 1 cycle while in BUS, then a full write frame -> stb low the next cycle, busy=0, no response byte; the following frame completes with tx 06.

Source files
------------

// File: rtl/ser_bus_master_pkg.sv
// Shared command/response codes and FSM state encoding for the serial bus master.
package ser_bus_master_pkg;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  localparam logic [2:0] RD_RESP_BYTES = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

endpackage

// File: rtl/ser_bus_master.sv
// Serial-command bus initiator: rx byte frames become single-word bus cycles,
// results go back out as tx bytes.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for a command byte
// S_ADDR | collecting 3 byte-address bytes, MSB first
// S_DATA | collecting 4 write-data bytes, MSB first
// S_BUS  | strobe held until ack or timeout
// S_RESP | streaming response bytes to the transmitter
module ser_bus_master
  import ser_bus_master_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [21:0] bus_addr,
  output logic [31:0] bus_dout,
  input  logic [31:0] bus_din,
  input  logic        bus_ack,
  output logic        busy
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  byte_cnt;
  logic        is_write;
  logic [23:0] shift_in;
  logic [15:0] tmo_cnt;
  logic [23:0] resp_shift;
  logic [2:0]  resp_left;

  logic        rx_fire;
  logic        tx_fire;
  logic [31:0] rx_word;

  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;
  // Assembly value including the byte being accepted this cycle.
  assign rx_word = {shift_in, rx_data};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      byte_cnt   <= 2'd0;
      is_write   <= 1'b0;
      shift_in   <= 24'd0;
      tmo_cnt    <= 16'd0;
      resp_shift <= 24'd0;
      resp_left  <= 3'd0;
      rx_ready   <= 1'b0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      bus_stb    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 22'd0;
      bus_dout   <= 32'd0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          rx_ready <= 1'b1;
          if (rx_fire) begin
            busy     <= 1'b1;
            byte_cnt <= 2'd0;
            if (rx_data == CMD_READ || rx_data == CMD_WRITE) begin
              is_write <= (rx_data == CMD_WRITE);
              state    <= S_ADDR;
            end else begin
              rx_ready  <= 1'b0;
              tx_valid  <= 1'b1;
              tx_data   <= RSP_NAK;
              resp_left <= 3'd1;
              state     <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (rx_fire) begin
            shift_in <= rx_word[23:0];
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd2) begin
              byte_cnt <= 2'd0;
              bus_addr <= rx_word[23:2];
              bus_we   <= is_write;
              if (is_write) begin
                state <= S_DATA;
              end else begin
                rx_ready <= 1'b0;
                bus_stb  <= 1'b1;
                tmo_cnt  <= 16'd0;
                state    <= S_BUS;
              end
            end
          end
        end

        S_DATA: begin
          if (rx_fire) begin
            shift_in <= rx_word[23:0];
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              bus_dout <= rx_word;
              rx_ready <= 1'b0;
              bus_stb  <= 1'b1;
              tmo_cnt  <= 16'd0;
              state    <= S_BUS;
            end
          end
        end

        S_BUS: begin
          // Ack wins over a timeout expiring on the same edge.
          if (bus_ack) begin
            bus_stb  <= 1'b0;
            tx_valid <= 1'b1;
            state    <= S_RESP;
            if (is_write) begin
              tx_data   <= RSP_ACK;
              resp_left <= 3'd1;
            end else begin
              tx_data    <= bus_din[31:24];
              resp_shift <= bus_din[23:0];
              resp_left  <= RD_RESP_BYTES;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            bus_stb   <= 1'b0;
            tx_valid  <= 1'b1;
            tx_data   <= RSP_NAK;
            resp_left <= 3'd1;
            state     <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        S_RESP: begin
          if (tx_fire) begin
            if (resp_left == 3'd1) begin
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              rx_ready <= 1'b1;
              state    <= S_IDLE;
            end else begin
              tx_data    <= resp_shift[23:16];
              resp_shift <= {resp_shift[15:0], 8'h00};
              resp_left  <= resp_left - 3'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ser_bus_master.sv
// Directed plus randomized frames against a frame-level reference model.
module tb_ser_bus_master;

  localparam int TMO = 16;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        bus_stb;
  logic        bus_we;
  logic [21:0] bus_addr;
  logic [31:0] bus_dout;
  logic [31:0] bus_din;
  logic        bus_ack;
  logic        busy;

  int          ack_delay = 0;
  logic [31:0] slave_din = 32'h0;
  int          stb_age = 0;
  int          passed = 0;
  int          total = 0;

  ser_bus_master #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_dout(bus_dout), .bus_din(bus_din), .bus_ack(bus_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // Slave: acks in the (ack_delay+1)-th cycle of the strobe; negative = never.
  always @(posedge clk) stb_age <= bus_stb ? stb_age + 1 : 0;
  assign bus_ack = bus_stb && (ack_delay >= 0) && (stb_age == ack_delay);
  assign bus_din = slave_din;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("rx_accept", longint'(rx_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input bq_t fr, input int delay, input logic [31:0] din,
                           input int mode, input bit hold_rx);
    bq_t         exp_rsp;
    bq_t         got;
    int          cmd, n, stb_len;
    bit          is_cmd, ok, stable, quiet, stalled;
    logic [21:0] ea;
    logic [31:0] ed;
    logic [7:0]  held;

    ack_delay = delay;
    slave_din = din;
    cmd    = int'(fr[0]);
    is_cmd = (cmd == 1 || cmd == 2);
    ok     = is_cmd && delay >= 0 && delay < TMO;
    stb_len = ok ? delay + 1 : TMO;
    ea = 22'(0);
    ed = 32'(0);
    if (is_cmd) ea = 22'((int'(fr[1]) * 65536 + int'(fr[2]) * 256 + int'(fr[3])) / 4);
    if (cmd == 2)
      ed = 32'(longint'(fr[4]) * 16777216 + longint'(fr[5]) * 65536 +
               longint'(fr[6]) * 256 + longint'(fr[7]));
    if (!ok) exp_rsp.push_back(8'h15);
    else if (cmd == 2) exp_rsp.push_back(8'h06);
    else for (int k = 3; k >= 0; k--) exp_rsp.push_back(8'((din >> (8 * k)) & 32'hFF));

    foreach (fr[i]) send_byte(fr[i]);
    if (hold_rx) rx_data = 8'hA5;
    else rx_valid = 1'b0;

    if (is_cmd) begin
      check("stb_rise", longint'(bus_stb), 1);
      check("bus_addr", longint'(bus_addr), longint'(ea));
      check("bus_we", longint'(bus_we), longint'(cmd == 2));
      if (cmd == 2) check("bus_dout", longint'(bus_dout), longint'(ed));
      stable = 1'b1;
      quiet  = 1'b1;
      n = 0;
      while (bus_stb && n < TMO + 8) begin
        if (bus_addr !== ea || bus_we !== (cmd == 2)) stable = 1'b0;
        if (cmd == 2 && bus_dout !== ed) stable = 1'b0;
        if (rx_ready || !busy) quiet = 1'b0;
        @(posedge clk); #1;
        n++;
      end
      check("stb_len", n, stb_len);
      check("bus_stable", longint'(stable), 1);
      check("bus_quiet", longint'(quiet), 1);
    end else begin
      check("no_stb", longint'(bus_stb), 0);
    end

    check("tx_first", longint'(tx_valid), 1);
    quiet   = 1'b1;
    stable  = 1'b1;
    stalled = 1'b0;
    held    = 8'h00;
    n = 0;
    while (got.size() < exp_rsp.size() && n < 200) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (n % 3 == 2);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (bus_stb || rx_ready || !busy) quiet = 1'b0;
      if (stalled && (!tx_valid || tx_data !== held)) stable = 1'b0;
      if (tx_valid) begin
        if (tx_ready) begin
          got.push_back(tx_data);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = tx_data;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    tx_ready = 1'b0;
    check("rsp_len", got.size(), exp_rsp.size());
    for (int i = 0; i < got.size() && i < exp_rsp.size(); i++)
      check("rsp_byte", longint'(got[i]), longint'(exp_rsp[i]));
    check("tx_stall_stable", longint'(stable), 1);
    check("resp_quiet", longint'(quiet), 1);
    check("tx_done", longint'(tx_valid), 0);
    check("busy_done", longint'(busy), 0);
    check("rx_ready_idle", longint'(rx_ready), 1);
    if (hold_rx) rx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t fr;
    bit  quiet;
    int  r;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_ready", longint'(rx_ready), 0);
    check("rst_tx_valid", longint'(tx_valid), 0);
    check("rst_tx_data", longint'(tx_data), 0);
    check("rst_stb", longint'(bus_stb), 0);
    check("rst_we", longint'(bus_we), 0);
    check("rst_addr", longint'(bus_addr), 0);
    check("rst_dout", longint'(bus_dout), 0);
    check("rst_busy", longint'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rx_ready_after_rst", longint'(rx_ready), 1);

    // Read, ack in third strobe cycle
    fr = {8'h01, 8'hFF, 8'hFF, 8'hC4};
    run_frame(fr, 2, 32'h12345678, 0, 1'b0);

    // Write, immediate ack
    fr = {8'h02, 8'h00, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(fr, 0, 32'h0, 0, 1'b0);

    // Bad command then a normal read with minimum latency
    fr = {8'h7F};
    run_frame(fr, 0, 32'h0, 0, 1'b0);
    fr = {8'h01, 8'h12, 8'h34, 8'h56};
    run_frame(fr, 0, 32'hCAFEF00D, 0, 1'b0);

    // Timeout, and ack boundaries around it
    fr = {8'h01, 8'h00, 8'h00, 8'h10};
    run_frame(fr, -1, 32'hFFFFFFFF, 0, 1'b0);
    run_frame(fr, TMO - 1, 32'hA1B2C3D4, 0, 1'b0);
    run_frame(fr, TMO, 32'hA1B2C3D4, 0, 1'b0);
    fr = {8'h02, 8'h00, 8'h00, 8'h20, 8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(fr, -1, 32'h0, 0, 1'b0);

    // Backpressure: 1-of-3 tx_ready, rx held valid during BUS/RESP
    fr = {8'h01, 8'hAB, 8'hCD, 8'hEF};
    run_frame(fr, 1, 32'h89ABCDEF, 1, 1'b1);

    // Reset pulse while in BUS
    fr = {8'h01, 8'h00, 8'h40, 8'h00};
    ack_delay = -1;
    foreach (fr[i]) send_byte(fr[i]);
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bus_before_rst", longint'(bus_stb), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_stb", longint'(bus_stb), 0);
    check("rst_mid_busy", longint'(busy), 0);
    check("rst_mid_tx", longint'(tx_valid), 0);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (tx_valid || bus_stb || busy) quiet = 1'b0;
    end
    check("rst_mid_quiet", longint'(quiet), 1);
    fr = {8'h02, 8'h00, 8'h01, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88};
    run_frame(fr, 1, 32'h0, 0, 1'b0);

    // Randomized frames
    for (int t = 0; t < 24; t++) begin
      int delay;
      fr = {};
      r = $urandom_range(0, 7);
      if (r == 0) begin
        do r = $urandom_range(0, 255); while (r == 1 || r == 2);
        fr.push_back(8'(r));
      end else begin
        fr.push_back((r < 4) ? 8'h02 : 8'h01);
        repeat (3) fr.push_back(8'($urandom_range(0, 255)));
        if (fr[0] == 8'h02) repeat (4) fr.push_back(8'($urandom_range(0, 255)));
      end
      r = $urandom_range(0, 9);
      if (r == 0) delay = -1;
      else if (r == 1) delay = TMO - 1;
      else if (r == 2) delay = TMO;
      else delay = $urandom_range(0, 5);
      run_frame(fr, delay, $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
